// File: rtl/cpu_branch_resolver.sv
// cpu_branch_resolver: in-order branch prediction queue. Fetch pushes
// predictions and execute resolves them oldest-first. Each resolve produces
// a registered predictor-training pulse and, on a mispredict, a redirect.
// A mispredict also discards every younger entry still in the queue.
//
// Optional feature: define CPU_BRANCH_RESOLVER_STATS_EN to enable the
// resolved-branch and mispredict counters. When it is undefined, both stat
// outputs are tied to 0.
module cpu_branch_resolver #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WIDTH = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pred_valid,
  output logic                 pred_ready,
  input  logic [XLEN-1:0]      pred_addr,
  input  logic                 pred_taken,
  input  logic [XLEN-1:0]      pred_target,
  input  logic                 resolve_valid,
  input  logic                 resolve_taken,
  input  logic [XLEN-1:0]      resolve_target,
  input  logic                 flush,
  output logic                 update,
  output logic [XLEN-1:0]      update_addr,
  output logic                 update_taken,
  output logic                 mispredict,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 empty,
  output logic [CNT_WIDTH-1:0] stat_branches,
  output logic [CNT_WIDTH-1:0] stat_mispredicts
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0]   FULL_COUNT = (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0]   CNT_ONE    = (DEPTH_WIDTH+1)'(1);
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE    = DEPTH_WIDTH'(1);
  localparam logic [XLEN-1:0]        PC_STEP    = XLEN'(4);

  // Queue storage. There is no reset: an entry is meaningful only while
  // count covers it.
  logic [XLEN-1:0] addr_mem   [DEPTH];
  logic            taken_mem  [DEPTH];
  logic [XLEN-1:0] target_mem [DEPTH];

  logic [DEPTH_WIDTH-1:0] head_reg, tail_reg;
  logic [DEPTH_WIDTH:0]   count_reg, count_next;

  logic            push_fire, pop_fire, mis_fire;
  logic [XLEN-1:0] head_addr, head_target;
  logic            head_taken;

  assign head_addr   = addr_mem[head_reg];
  assign head_taken  = taken_mem[head_reg];
  assign head_target = target_mem[head_reg];

  // Refuse pushes when full, even when a pop happens in the same cycle, and
  // during a flush.
  assign pred_ready = (count_reg != FULL_COUNT) && !flush;
  assign push_fire  = pred_valid && pred_ready;
  // A resolve with nothing outstanding is a protocol error and is ignored.
  assign pop_fire   = resolve_valid && (count_reg != '0);
  assign mis_fire   = pop_fire &&
                      ((head_taken != resolve_taken) ||
                       (resolve_taken && (head_target != resolve_target)));
  assign empty      = (count_reg == '0);

  // Occupancy after a normal push/pop; flushes override this in the register.
  always_comb begin
    count_next = count_reg;
    if (push_fire && !pop_fire) begin
      count_next = count_reg + CNT_ONE;
    end else if (pop_fire && !push_fire) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  // Write accepted predictions. A push that coincides with a mispredict is
  // younger than the bad branch, so it is dropped.
  always_ff @(posedge clk) begin
    if (push_fire && !mis_fire) begin
      addr_mem[tail_reg]   <= pred_addr;
      taken_mem[tail_reg]  <= pred_taken;
      target_mem[tail_reg] <= pred_target;
    end
  end

  // Pointer and occupancy bookkeeping, including both flavours of flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (mis_fire || flush) begin
      // Pushes are blocked by flush or dropped by a mispredict, so tail stays
      // where it is and the queue collapses onto it.
      head_reg  <= tail_reg;
      count_reg <= '0;
    end else begin
      if (pop_fire) begin
        head_reg <= head_reg + PTR_ONE;
      end
      if (push_fire) begin
        tail_reg <= tail_reg + PTR_ONE;
      end
      count_reg <= count_next;
    end
  end

  // Registered training and redirect outputs, one cycle after the pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      update       <= 1'b0;
      mispredict   <= 1'b0;
      update_addr  <= '0;
      update_taken <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      update     <= pop_fire;
      mispredict <= mis_fire;
      if (pop_fire) begin
        update_addr  <= head_addr;
        update_taken <= resolve_taken;
      end
      if (mis_fire) begin
        redirect_pc <= resolve_taken ? resolve_target : (head_addr + PC_STEP);
      end
    end
  end

`ifdef CPU_BRANCH_RESOLVER_STATS_EN
  localparam logic [CNT_WIDTH-1:0] STAT_ONE = CNT_WIDTH'(1);
  logic [CNT_WIDTH-1:0] stat_branches_reg, stat_mispredicts_reg;

  // Performance counters advance at the pop edge and wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else begin
      if (pop_fire) begin
        stat_branches_reg <= stat_branches_reg + STAT_ONE;
      end
      if (mis_fire) begin
        stat_mispredicts_reg <= stat_mispredicts_reg + STAT_ONE;
      end
    end
  end

  assign stat_branches    = stat_branches_reg;
  assign stat_mispredicts = stat_mispredicts_reg;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_cpu_branch_resolver.sv
// Testbench for cpu_branch_resolver (default parameters, DEPTH = 4).
// A table of per-cycle vectors drives the block. The expected outputs for
// each cycle are queued when the vector is driven and checked after the edge.
module tb_cpu_branch_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_ready, pred_taken;
  logic [31:0] pred_addr, pred_target;
  logic        resolve_valid, resolve_taken;
  logic [31:0] resolve_target;
  logic        flush;
  logic        update, update_taken, mispredict, empty;
  logic [31:0] update_addr, redirect_pc;
  logic [31:0] stat_branches, stat_mispredicts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_branch_resolver dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_ready(pred_ready),
    .pred_addr(pred_addr), .pred_taken(pred_taken), .pred_target(pred_target),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target), .flush(flush),
    .update(update), .update_addr(update_addr), .update_taken(update_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .empty(empty),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  typedef struct {
    logic        pv;  logic [31:0] pa;  logic pt;  logic [31:0] ptg;
    logic        rv;  logic        rt;  logic [31:0] rtg;
    logic        fl;  logic        rs;
    logic        x_ready;
    logic        x_upd; logic [31:0] x_uaddr; logic x_utaken;
    logic        x_mis; logic [31:0] x_rpc;
    logic        x_empty;
  } vec_t;

  typedef struct {
    logic        upd; logic [31:0] uaddr; logic utaken;
    logic        mis; logic [31:0] rpc;   logic emp;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic add(input logic pv, input logic [31:0] pa, input logic pt, input logic [31:0] ptg,
                     input logic rv, input logic rt, input logic [31:0] rtg,
                     input logic fl, input logic rs, input logic x_ready,
                     input logic x_upd, input logic [31:0] x_uaddr, input logic x_utaken,
                     input logic x_mis, input logic [31:0] x_rpc, input logic x_empty);
    vec_t v;
    v.pv = pv; v.pa = pa; v.pt = pt; v.ptg = ptg;
    v.rv = rv; v.rt = rt; v.rtg = rtg; v.fl = fl; v.rs = rs;
    v.x_ready = x_ready; v.x_upd = x_upd; v.x_uaddr = x_uaddr; v.x_utaken = x_utaken;
    v.x_mis = x_mis; v.x_rpc = x_rpc; v.x_empty = x_empty;
    vecs.push_back(v);
  endtask

  // Plain push into a non-full queue; the queue is non-empty afterwards.
  task automatic add_push(input logic [31:0] pa, input logic pt, input logic [31:0] ptg);
    add(1, pa, pt, ptg, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  // Plain resolve with its expected training/redirect outcome.
  task automatic add_res(input logic rt, input logic [31:0] rtg, input logic [31:0] ua,
                         input logic mis, input logic [31:0] rpc, input logic emp);
    add(0, 0, 0, 0, 1, rt, rtg, 0, 0, 1, 1, ua, rt, mis, rpc, emp);
  endtask

  task automatic add_idle(input logic emp);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, emp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_br, exp_mp;
    exp_t e;

    // Correct taken prediction: update only, then update clears.
    add_push(32'h100, 1, 32'h200);
    add_res(1, 32'h200, 32'h100, 0, 0, 1);
    add_idle(1);
    // Direction wrong: redirect to the actual target and drop the younger entry.
    add_push(32'h100, 0, 32'h0);
    add_push(32'h104, 1, 32'h300);
    add_res(1, 32'h180, 32'h100, 1, 32'h180, 1);
    add_idle(1);
    // Direction right, target wrong.
    add_push(32'h40, 1, 32'h80);
    add_res(1, 32'h90, 32'h40, 1, 32'h90, 1);
    // Predicted taken, actually not-taken at the top of the address space:
    // the fall-through wraps to 0. A push in the same cycle is dropped.
    add_push(32'hFFFF_FFFC, 1, 32'h10);
    add(1, 32'h500, 0, 0, 1, 0, 32'h0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 1, 32'h0, 1);
    add_idle(1);
    // Fill all four entries.
    for (int k = 0; k < 4; k++) add_push(32'h10 + 32'(4*k), 0, 32'h0);
    // Full: the push is refused although a pop happens in the same cycle.
    add(1, 32'h20, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h10, 0, 0, 0, 0);
    // Eight push+pop cycles at occupancy 3 wrap both pointers.
    for (int k = 0; k < 8; k++)
      add(1, 32'h20 + 32'(4*k), 0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h14 + 32'(4*k), 0, 0, 0, 0);
    // Drain the last three entries in order.
    add_res(0, 0, 32'h34, 0, 0, 0);
    add_res(0, 0, 32'h38, 0, 0, 0);
    add_res(0, 0, 32'h3C, 0, 0, 1);
    // A resolve while empty is ignored.
    add(0, 0, 0, 0, 1, 1, 32'h77, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add_idle(1);
    // Reset with three entries outstanding, then a new prediction is accepted.
    for (int k = 0; k < 3; k++) add_push(32'h700 + 32'(4*k), 1, 32'h900);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    add_push(32'h800, 1, 32'h900);
    add_res(1, 32'h900, 32'h800, 0, 0, 1);
    // Flush together with a resolve: pop completes, the rest is discarded,
    // and the concurrent push is blocked.
    add_push(32'hA00, 0, 32'h0);
    add_push(32'hA04, 1, 32'hB00);
    add(1, 32'hC00, 0, 0, 1, 0, 0, 1, 0, 0, 1, 32'hA00, 0, 0, 0, 1);
    add_idle(1);
    // Flush alone discards the queue without any update.
    add_push(32'hD00, 1, 32'hD80);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add_idle(1);
    // Two more mispredicts so the counters see a mix.
    add_push(32'hE00, 0, 32'h0);
    add_res(1, 32'hE40, 32'hE00, 1, 32'hE40, 1);
    add_push(32'hE10, 1, 32'hE80);
    add_res(0, 0, 32'hE10, 1, 32'hE14, 1);

    // Initial reset and reset-state checks.
    rst = 1; pred_valid = 0; pred_addr = 0; pred_taken = 0; pred_target = 0;
    resolve_valid = 0; resolve_taken = 0; resolve_target = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset update", 32'(update), 0);
    check("reset mispredict", 32'(mispredict), 0);
    check("reset update_addr", update_addr, 0);
    check("reset update_taken", 32'(update_taken), 0);
    check("reset redirect_pc", redirect_pc, 0);
    check("reset empty", 32'(empty), 1);
    check("reset stat_branches", stat_branches, 0);
    check("reset stat_mispredicts", stat_mispredicts, 0);
    @(negedge clk);
    rst = 0;
    #1;
    check("reset pred_ready", 32'(pred_ready), 1);

    exp_br = 0;
    exp_mp = 0;
    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rs;
      pred_valid = vecs[i].pv; pred_addr = vecs[i].pa;
      pred_taken = vecs[i].pt; pred_target = vecs[i].ptg;
      resolve_valid = vecs[i].rv; resolve_taken = vecs[i].rt;
      resolve_target = vecs[i].rtg; flush = vecs[i].fl;
      #1;
      check($sformatf("v%0d pred_ready", i), 32'(pred_ready), 32'(vecs[i].x_ready));
      e.upd = vecs[i].x_upd; e.uaddr = vecs[i].x_uaddr; e.utaken = vecs[i].x_utaken;
      e.mis = vecs[i].x_mis; e.rpc = vecs[i].x_rpc; e.emp = vecs[i].x_empty;
      exp_q.push_back(e);
      if (vecs[i].rs) begin
        exp_br = 0;
        exp_mp = 0;
      end else begin
        exp_br += int'(vecs[i].x_upd);
        exp_mp += int'(vecs[i].x_mis);
      end

      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      $display("v%0d: upd=%0b addr=%h taken=%0b mis=%0b rpc=%h empty=%0b",
               i, update, update_addr, update_taken, mispredict, redirect_pc, empty);
      check($sformatf("v%0d update", i), 32'(update), 32'(e.upd));
      check($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(e.mis));
      check($sformatf("v%0d empty", i), 32'(empty), 32'(e.emp));
      if (e.upd) begin
        check($sformatf("v%0d update_addr", i), update_addr, e.uaddr);
        check($sformatf("v%0d update_taken", i), 32'(update_taken), 32'(e.utaken));
      end
      if (e.mis) check($sformatf("v%0d redirect_pc", i), redirect_pc, e.rpc);
`ifdef CPU_BRANCH_RESOLVER_STATS_EN
      check($sformatf("v%0d stat_branches", i), stat_branches, 32'(exp_br));
      check($sformatf("v%0d stat_mispredicts", i), stat_mispredicts, 32'(exp_mp));
`else
      check($sformatf("v%0d stat_branches", i), stat_branches, 32'(0 * exp_br));
      check($sformatf("v%0d stat_mispredicts", i), stat_mispredicts, 32'(0 * exp_mp));
`endif
    end

    @(negedge clk);
    pred_valid = 0;
    resolve_valid = 0;
    flush = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
